// File: rtl/inert_serf.sv
// inert_serf: SPI responder that models a gyro sensor for bring-up and full-chip simulation.
// It decodes 16-bit command frames, holds a small register file, samples the yaw rate at a
// fixed output data rate, and raises a level data-ready interrupt.
module inert_serf #(
  parameter logic [15:0] ODR_CYCLES   = 16'd2048,
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] yaw_rt_in,
  output logic        gyro_en,
  output logic [7:0]  ovr_cnt
);

  typedef enum logic {FRAME_IDLE, FRAME_ACTIVE} frame_state_e;

  logic ssMeta_q, ssSync_q, ssPrev_q;
  logic sclkMeta_q, sclkSync_q, sclkPrev_q;
  logic mosiMeta_q, mosiSync_q;
  logic ssFall, ssRise, sclkRise, sclkFall;

  frame_state_e state_q, state_d;
  logic [4:0]   bitCnt_q, bitCnt_d;
  logic         bitOvf_q, bitOvf_d;
  logic [7:0]   rx_q, rx_d;
  logic [7:0]   tx_q, tx_d;
  logic [7:0]   cmd_q, cmd_d;
  logic         frameDone;

  logic [6:0]   rdAddr;
  logic [7:0]   rdData;
  logic         wrEn, intClr;

  logic [7:0]   int1Ctrl_q, ctrl2G_q, ctrl5_q;
  logic [15:0]  snapshot_q, snapshot_d;
  logic [15:0]  timer_q, timer_d;
  logic         int_q, int_d;
  logic [7:0]   ovr_q, ovr_d;
  logic         sampleEvt;

  // Synchronize the SPI pins into clk; left unreset so a select held low through reset
  // never looks like a fresh falling edge afterwards.
  always_ff @(posedge clk) begin
    ssMeta_q   <= SS_n;
    ssSync_q   <= ssMeta_q;
    ssPrev_q   <= ssSync_q;
    sclkMeta_q <= SCLK;
    sclkSync_q <= sclkMeta_q;
    sclkPrev_q <= sclkSync_q;
    mosiMeta_q <= MOSI;
    mosiSync_q <= mosiMeta_q;
  end

  assign ssFall   =  ssPrev_q   & ~ssSync_q;
  assign ssRise   = ~ssPrev_q   &  ssSync_q;
  assign sclkRise = ~sclkPrev_q &  sclkSync_q;
  assign sclkFall =  sclkPrev_q & ~sclkSync_q;

  // Frame state and shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FRAME_IDLE;
      bitCnt_q <= '0;
      bitOvf_q <= 1'b0;
      rx_q     <= '0;
      tx_q     <= '0;
      cmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      bitOvf_q <= bitOvf_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      cmd_q    <= cmd_d;
    end
  end

  // Frame sequencing: count rises, capture the command byte, load and shift read data.
  // rx only needs one byte: the command is captured at bit 8, the write data sits in rx at bit 16.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    bitOvf_d  = bitOvf_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    cmd_d     = cmd_q;
    frameDone = 1'b0;
    case (state_q)
      FRAME_IDLE: begin
        if (ssFall) begin
          state_d  = FRAME_ACTIVE;
          bitCnt_d = '0;
          bitOvf_d = 1'b0;
          rx_d     = '0;
          tx_d     = '0;
        end
      end
      FRAME_ACTIVE: begin
        if (ssRise) begin
          state_d   = FRAME_IDLE;
          frameDone = (bitCnt_q == 5'd16) && !bitOvf_q;
        end else if (sclkRise) begin
          if (bitCnt_q == 5'd16) begin
            bitOvf_d = 1'b1;
          end else begin
            rx_d     = {rx_q[6:0], mosiSync_q};
            bitCnt_d = bitCnt_q + 5'd1;
            if (bitCnt_q == 5'd7) begin
              cmd_d = {rx_q[6:0], mosiSync_q};
              tx_d  = rx_q[6] ? rdData : 8'h00;
            end
          end
        end else if (sclkFall && (bitCnt_q >= 5'd9) && (bitCnt_q <= 5'd15)) begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
      default: state_d = FRAME_IDLE;
    endcase
  end

  assign rdAddr = {rx_q[5:0], mosiSync_q};

  // Register read mux, addressed by the command byte as it completes.
  always_comb begin
    rdData = 8'h00;
    case (rdAddr)
      7'h0D:   rdData = int1Ctrl_q;
      7'h0F:   rdData = WHO_AM_I_VAL;
      7'h11:   rdData = ctrl2G_q;
      7'h14:   rdData = ctrl5_q;
      7'h26:   rdData = snapshot_q[7:0];
      7'h27:   rdData = snapshot_q[15:8];
      default: rdData = 8'h00;
    endcase
  end

  assign MISO   = (state_q == FRAME_ACTIVE) & ~ssSync_q & tx_q[7];
  assign wrEn   = frameDone & ~cmd_q[7];
  assign intClr = frameDone &  cmd_q[7] & (cmd_q[6:0] == 7'h27);

  // Commit writes to the writable registers at the end of a complete frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      int1Ctrl_q <= '0;
      ctrl2G_q   <= '0;
      ctrl5_q    <= '0;
    end else if (wrEn) begin
      case (cmd_q[6:0])
        7'h0D:   int1Ctrl_q <= rx_q;
        7'h11:   ctrl2G_q   <= rx_q;
        7'h14:   ctrl5_q    <= rx_q;
        default: ;
      endcase
    end
  end

  assign gyro_en   = int1Ctrl_q[1] & (ctrl2G_q[7:4] != 4'd0);
  assign sampleEvt = gyro_en && (timer_q == ODR_CYCLES - 16'd1);

  // ODR timer, sample snapshot, interrupt and overrun count; a read clear lands before a
  // coincident sample so the fresh sample is taken rather than counted as missed.
  always_comb begin
    timer_d    = timer_q;
    snapshot_d = snapshot_q;
    ovr_d      = ovr_q;
    int_d      = int_q & ~intClr;
    if (!gyro_en) begin
      timer_d = '0;
      int_d   = 1'b0;
    end else begin
      timer_d = sampleEvt ? 16'd0 : timer_q + 16'd1;
      if (sampleEvt) begin
        if (!int_d) begin
          snapshot_d = yaw_rt_in;
          int_d      = 1'b1;
        end else if (ovr_q != 8'hFF) begin
          ovr_d = ovr_q + 8'd1;
        end
      end
    end
  end

  // Sampling state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      snapshot_q <= '0;
      ovr_q      <= '0;
      int_q      <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      snapshot_q <= snapshot_d;
      ovr_q      <= ovr_d;
      int_q      <= int_d;
    end
  end

  assign INT     = int_q;
  assign ovr_cnt = ovr_q;

endmodule
